main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm_pkg.sv | 41 ++++
 rtl/main_fsm.sv | 137 +++++++++++++
 tb/tb_main_fsm.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle processor control FSM: state codes,
// opcode field values and datapath select encodings.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Moore control FSM for a multicycle MIPS-style datapath. Outputs decode the
// state register; only pcen also looks at the ALU zero flag.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic       w_iord, w_irwrite, w_memwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_pcwrite, w_branch;
  logic [1:0] w_alusrcb, w_pcsrc, w_aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      // op is held by the instruction register, so only lw/sw can reach here
      S_MEMADR: begin
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_iord     = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_alusrcb  = SRCB_REG;
    w_pcsrc    = PCSRC_ALU;
    w_aluop    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = SRCB_FOUR;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: w_alusrcb = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
      end
      S_MEMRD: w_iord = 1'b1;
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_REG;
        w_aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_REG;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = PCSRC_ALUOUT;
        w_branch  = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        w_pcsrc   = PCSRC_JUMP;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are masked by reset itself so nothing commits while it is held
  assign iord     = w_iord;
  assign irwrite  = w_irwrite & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign regdst   = w_regdst;
  assign memtoreg = w_memtoreg;
  assign regwrite = w_regwrite & ~reset;
  assign alusrca  = w_alusrca;
  assign alusrcb  = w_alusrcb;
  assign pcsrc    = w_pcsrc;
  assign aluop    = w_aluop;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;
  assign state    = r_state;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: instruction-sequence reference model with per-cycle
// compare, directed instruction walks, and a second instance for HALT mode.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset, zero;
  logic [5:0] op;
  logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  logic       h_reset, h_zero;
  logic [5:0] h_op;
  logic       h_iord, h_irwrite, h_memwrite, h_regdst, h_memtoreg, h_regwrite, h_alusrca, h_pcen;
  logic [1:0] h_alusrcb, h_pcsrc, h_aluop;
  logic [3:0] h_state;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  main_fsm #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen), .state(state)
  );

  main_fsm #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .reset(h_reset), .op(h_op), .zero(h_zero),
    .iord(h_iord), .irwrite(h_irwrite), .memwrite(h_memwrite), .regdst(h_regdst),
    .memtoreg(h_memtoreg), .regwrite(h_regwrite), .alusrca(h_alusrca),
    .alusrcb(h_alusrcb), .pcsrc(h_pcsrc), .aluop(h_aluop), .pcen(h_pcen), .state(h_state)
  );

  // Number of states an instruction visits, FETCH included
  function automatic int seq_len(logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  // k-th state visited by an instruction with opcode o
  function automatic int seq_at(logic [5:0] o, int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    if (k == 2) begin
      case (o)
        6'b100011, 6'b101011: return 2;
        6'b000000: return 6;
        6'b000100: return 8;
        6'b001000: return 9;
        6'b000010: return 11;
        default:   return 0;
      endcase
    end
    if (k == 3) begin
      case (o)
        6'b100011: return 3;
        6'b101011: return 5;
        6'b000000: return 7;
        6'b001000: return 10;
        default:   return 0;
      endcase
    end
    return 4;
  endfunction

  // {iord,irwrite,memwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop,pcwrite,branch}
  function automatic logic [14:0] ctl(int s);
    case (s)
      0:  return 15'b0_1_0_0_0_0_0_01_00_00_1_0;
      1:  return 15'b0_0_0_0_0_0_0_11_00_00_0_0;
      2:  return 15'b0_0_0_0_0_0_1_10_00_00_0_0;
      3:  return 15'b1_0_0_0_0_0_0_00_00_00_0_0;
      4:  return 15'b0_0_0_0_1_1_0_00_00_00_0_0;
      5:  return 15'b1_0_1_0_0_0_0_00_00_00_0_0;
      6:  return 15'b0_0_0_0_0_0_1_00_00_10_0_0;
      7:  return 15'b0_0_0_1_0_1_0_00_00_00_0_0;
      8:  return 15'b0_0_0_0_0_0_1_00_01_01_0_1;
      9:  return 15'b0_0_0_0_0_0_1_10_00_00_0_0;
      10: return 15'b0_0_0_0_0_1_0_00_00_00_0_0;
      11: return 15'b0_0_0_0_0_0_0_00_10_00_1_0;
      default: return 15'b0;
    endcase
  endfunction

  // Reference model: position within the current instruction
  int         m_idx = 0;
  logic [5:0] m_op  = 6'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idx <= 0;
    end else if (m_idx == 0) begin
      m_op  <= op;
      m_idx <= 1;
    end else if (m_idx + 1 >= seq_len(m_op)) begin
      m_idx <= 0;
    end else begin
      m_idx <= m_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int          es;
      logic [14:0] e;
      logic        ep;
      es = reset ? 0 : seq_at(m_op, m_idx);
      e  = ctl(es);
      if (reset) begin
        e[13] = 1'b0;
        e[12] = 1'b0;
        e[9]  = 1'b0;
      end
      ep = !reset && (e[1] || (e[0] && zero));
      checks++;
      if (state !== 4'(es)) begin
        errors++;
        $display("FAIL model_state t=%0t got=%0d exp=%0d", $time, state, es);
      end
      checks++;
      if ({iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop} !== e[14:2]) begin
        errors++;
        $display("FAIL model_ctl t=%0t state=%0d got=%b exp=%b", $time, es,
                 {iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop}, e[14:2]);
      end
      checks++;
      if (pcen !== ep) begin
        errors++;
        $display("FAIL model_pcen t=%0t state=%0d got=%b exp=%b", $time, es, pcen, ep);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
    end else begin
      $display("check %s t=%0t value=%0d ok", name, $time, act);
    end
  endtask

  task automatic step(int exp_state);
    @(negedge clk);
    #1;
    chk("dir_state", int'(state), exp_state);
  endtask

  task automatic hstep(int exp_state);
    @(negedge clk);
    #1;
    chk("halt_state", int'(h_state), exp_state);
  endtask

  initial begin
    reset = 1'b1; op = 6'b100011; zero = 1'b0;
    h_reset = 1'b1; h_op = 6'b111111; h_zero = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_irwrite", int'(irwrite), 0);
    chk("rst_pcen", int'(pcen), 0);
    chk("rst_alusrcb", int'(alusrcb), 1);

    // lw: 0,1,2,3,4,0
    reset = 1'b0;
    chk("rel_state", int'(state), 0);
    step(1);
    step(2);
    step(3);
    chk("lw_regwrite_s3", int'(regwrite), 0);
    step(4);
    chk("lw_regwrite_s4", int'(regwrite), 1);
    chk("lw_memtoreg_s4", int'(memtoreg), 1);
    step(0);
    chk("lw_regwrite_s0", int'(regwrite), 0);

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    step(1);
    step(8);
    chk("beq_t_pcen", int'(pcen), 1);
    chk("beq_pcsrc", int'(pcsrc), 1);
    chk("beq_aluop", int'(aluop), 1);
    step(0);
    zero = 1'b0;
    step(1);
    step(8);
    chk("beq_nt_pcen", int'(pcen), 0);
    step(0);

    // R-type
    op = 6'b000000;
    step(1);
    step(6);
    chk("rtype_aluop", int'(aluop), 2);
    step(7);
    chk("rtype_regdst", int'(regdst), 1);
    step(0);

    // jump
    op = 6'b000010;
    step(1);
    step(11);
    chk("j_pcen", int'(pcen), 1);
    chk("j_pcsrc", int'(pcsrc), 2);
    step(0);

    // undefined opcode with ILLEGAL_HALT=0
    op = 6'b111111;
    step(1);
    step(0);

    // sw interrupted by reset during MEMWR
    op = 6'b101011;
    step(1);
    step(2);
    step(5);
    chk("sw_memwrite", int'(memwrite), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_memwrite", int'(memwrite), 0);
    chk("mid_rst_pcen", int'(pcen), 0);
    @(negedge clk);
    #1;
    chk("hold_rst_pcen", int'(pcen), 0);
    chk("hold_rst_state", int'(state), 0);
    reset = 1'b0;
    step(1);
    step(2);
    step(5);
    step(0);

    // ILLEGAL_HALT=1 instance
    h_reset = 1'b0;
    chk("halt_rel", int'(h_state), 0);
    hstep(1);
    hstep(12);
    for (int i = 0; i < 10; i++) begin
      hstep(12);
      chk("halt_pcen", int'(h_pcen), 0);
      chk("halt_regwrite", int'(h_regwrite), 0);
    end
    h_reset = 1'b1;
    #1;
    chk("halt_reset", int'(h_state), 0);
    @(negedge clk);
    h_reset = 1'b0;
    hstep(1);

    // Randomised run against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      if (reset) begin
        if ($urandom_range(0, 2) == 0) reset = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
      end
      if (!reset && m_idx == 0) begin
        case ($urandom_range(0, 6))
          0: op = 6'b100011;
          1: op = 6'b101011;
          2: op = 6'b000000;
          3: op = 6'b000100;
          4: op = 6'b001000;
          5: op = 6'b000010;
          default: op = 6'($urandom);
        endcase
      end
      zero = 1'($urandom);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
